// File: rtl/lrf_fuse_sequencer.sv
// Beat/frame sequencer for LRF frame fusion: stream handshake, accumulator strobes and output framing.
// Optional LRF_TLAST_RESYNC_EN: an early s_axis_tlast ends the current frame instead of only flagging it.
module lrf_fuse_sequencer #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int FUSE_COUNT      = 16,
    localparam int BEATS  = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    localparam int ADDR_W = $clog2(BEATS),
    localparam int FRM_W  = (FUSE_COUNT > 1) ? $clog2(FUSE_COUNT) : 1
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    input  logic              enable,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              acc_wr,
    output logic              acc_clr,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [FRM_W-1:0]  frame_idx,
    output logic              fuse_done,
    output logic              err_tlast
);

    // state | meaning
    // IDLE  | waiting for enable, input not ready
    // FIRST | frame 0, accumulator overwritten (also the output frame when FUSE_COUNT==1)
    // ACCUM | frames 1..F-2, accumulator added
    // LAST  | frame F-1, input paced by output ready
    typedef enum logic [1:0] {IDLE, FIRST, ACCUM, LAST} state_t;

    localparam logic [ADDR_W-1:0] BEAT_END = ADDR_W'(BEATS - 1);
    localparam logic [FRM_W-1:0]  ACC_END  = FRM_W'((FUSE_COUNT > 2) ? FUSE_COUNT - 2 : 0);
    localparam bit                SINGLE   = (FUSE_COUNT == 1);

    state_t            state;
    logic [ADDR_W-1:0] beat_cnt;
    logic              active;
    logic              in_last;
    logic              at_end;
    logic              step;
    logic              wrap;

    assign active        = (state != IDLE);
    assign in_last       = (state == LAST) || (SINGLE && (state == FIRST));
    assign at_end        = (beat_cnt == BEAT_END);
    assign s_axis_tready = active && (in_last ? m_axis_tready : 1'b1);
    assign m_axis_tvalid = in_last && s_axis_tvalid;
    assign step          = s_axis_tvalid && s_axis_tready;
    assign acc_wr        = step;
    assign acc_clr       = (state == FIRST);
    assign acc_addr      = beat_cnt;

`ifdef LRF_TLAST_RESYNC_EN
    assign wrap         = step && (at_end || s_axis_tlast);
    assign m_axis_tlast = in_last && (at_end || (s_axis_tvalid && s_axis_tlast));
`else
    assign wrap         = step && at_end;
    assign m_axis_tlast = in_last && at_end;
`endif

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            frame_idx <= '0;
            fuse_done <= 1'b0;
            err_tlast <= 1'b0;
        end else begin
            fuse_done <= 1'b0;
            if (step && (s_axis_tlast != at_end))
                err_tlast <= 1'b1;
            if (step)
                beat_cnt <= wrap ? '0 : beat_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (enable)
                        state <= FIRST;
                end
                default: begin
                    if (wrap) begin
                        if (in_last) begin
                            // enable only matters here: a group in flight always completes
                            frame_idx <= '0;
                            fuse_done <= 1'b1;
                            state     <= enable ? FIRST : IDLE;
                        end else begin
                            frame_idx <= frame_idx + 1'b1;
                            if (state == FIRST)
                                state <= (FUSE_COUNT == 2) ? LAST : ACCUM;
                            else if (frame_idx == ACC_END)
                                state <= LAST;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lrf_fuse_sequencer.sv
// Directed bench for lrf_fuse_sequencer: BEATS=4 with FUSE_COUNT=3, plus a FUSE_COUNT=1 instance.
module tb_lrf_fuse_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // FUSE_COUNT=3 instance
    logic       rst, en, tv, tl, mr;
    logic       s_rdy, m_v, m_l, wr, clr, done, err;
    logic [1:0] addr;
    logic [1:0] frm;

    // FUSE_COUNT=1 instance
    logic       rst1, en1, tv1, tl1, mr1;
    logic       s_rdy1, m_v1, m_l1, wr1, clr1, done1, err1;
    logic [1:0] addr1;
    logic [0:0] frm1;

    lrf_fuse_sequencer #(.PIXELS_PER_BEAT(4), .IMAGE_DIM(4), .FUSE_COUNT(3)) dut (
        .s_axis_aclk(clk), .s_axis_areset(rst), .enable(en),
        .s_axis_tvalid(tv), .s_axis_tlast(tl), .s_axis_tready(s_rdy),
        .m_axis_tvalid(m_v), .m_axis_tready(mr), .m_axis_tlast(m_l),
        .acc_wr(wr), .acc_clr(clr), .acc_addr(addr), .frame_idx(frm),
        .fuse_done(done), .err_tlast(err)
    );

    lrf_fuse_sequencer #(.PIXELS_PER_BEAT(4), .IMAGE_DIM(4), .FUSE_COUNT(1)) dut1 (
        .s_axis_aclk(clk), .s_axis_areset(rst1), .enable(en1),
        .s_axis_tvalid(tv1), .s_axis_tlast(tl1), .s_axis_tready(s_rdy1),
        .m_axis_tvalid(m_v1), .m_axis_tready(mr1), .m_axis_tlast(m_l1),
        .acc_wr(wr1), .acc_clr(clr1), .acc_addr(addr1), .frame_idx(frm1),
        .fuse_done(done1), .err_tlast(err1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // inputs for the next cycle are driven just after this returns
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cyc(input string tag, input int e_rdy, input int e_wr, input int e_clr,
                           input int e_addr, input int e_frm, input int e_mv, input int e_ml,
                           input int e_done);
        @(negedge clk);
        check({tag, ".s_tready"}, int'(s_rdy), e_rdy);
        check({tag, ".acc_wr"},   int'(wr),    e_wr);
        check({tag, ".acc_clr"},  int'(clr),   e_clr);
        check({tag, ".acc_addr"}, int'(addr),  e_addr);
        check({tag, ".frame"},    int'(frm),   e_frm);
        check({tag, ".m_tvalid"}, int'(m_v),   e_mv);
        check({tag, ".m_tlast"},  int'(m_l),   e_ml);
        check({tag, ".done"},     int'(done),  e_done);
    endtask

    task automatic exp_cyc1(input string tag, input int e_rdy, input int e_wr, input int e_clr,
                            input int e_addr, input int e_mv, input int e_ml, input int e_done);
        @(negedge clk);
        check({tag, ".s_tready"}, int'(s_rdy1), e_rdy);
        check({tag, ".acc_wr"},   int'(wr1),    e_wr);
        check({tag, ".acc_clr"},  int'(clr1),   e_clr);
        check({tag, ".acc_addr"}, int'(addr1),  e_addr);
        check({tag, ".frame"},    int'(frm1),   0);
        check({tag, ".m_tvalid"}, int'(m_v1),   e_mv);
        check({tag, ".m_tlast"},  int'(m_l1),   e_ml);
        check({tag, ".done"},     int'(done1),  e_done);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tv = 1'b0; tl = 1'b0; mr = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; tv1 = 1'b0; tl1 = 1'b0; mr1 = 1'b0;
        nxt();
        nxt();
        exp_cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.err", int'(err), 0);

        // basic group
        nxt(); rst = 1'b0; en = 1'b1; tv = 1'b1; mr = 1'b1;
        exp_cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            nxt(); tl = (k % 4 == 3);
            exp_cyc($sformatf("grpA%0d", k), 1, 1, int'(k < 4), k % 4, k / 4,
                    int'(k >= 8), int'(k == 11), 0);
        end
        // next group back-to-back, fuse_done on its first beat
        for (int k = 0; k < 10; k++) begin
            nxt(); tl = (k % 4 == 3);
            exp_cyc($sformatf("grpB%0d", k), 1, 1, int'(k < 4), k % 4, k / 4,
                    int'(k >= 8), 0, int'(k == 0));
        end

        // output backpressure at LAST beat 2
        for (int c = 0; c < 5; c++) begin
            nxt(); mr = 1'b0; tl = 1'b0;
            exp_cyc($sformatf("bp%0d", c), 0, 0, 0, 2, 2, 1, 0, 0);
        end
        nxt(); mr = 1'b1;
        exp_cyc("bp_rel2", 1, 1, 0, 2, 2, 1, 0, 0);
        nxt(); tl = 1'b1;
        exp_cyc("bp_rel3", 1, 1, 0, 3, 2, 1, 1, 0);
        check("bp.err", int'(err), 0);

        // enable dropped mid-group: group completes, then IDLE
        for (int k = 0; k < 12; k++) begin
            nxt(); tl = (k % 4 == 3); en = (k < 4);
            exp_cyc($sformatf("grpC%0d", k), 1, 1, int'(k < 4), k % 4, k / 4,
                    int'(k >= 8), int'(k == 11), int'(k == 0));
        end
        nxt(); tl = 1'b0;
        exp_cyc("idle_after", 0, 0, 0, 0, 0, 0, 0, 1);
        nxt();
        exp_cyc("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        nxt(); en = 1'b1;
        exp_cyc("idle_en", 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        exp_cyc("restart", 1, 1, 1, 0, 0, 0, 0, 0);

        // early tlast at frame 0 beat 1
        nxt(); tl = 1'b1;
        exp_cyc("tl_early", 1, 1, 1, 1, 0, 0, 0, 0);
        check("tl_early.err", int'(err), 0);
        nxt(); tl = 1'b0;
`ifdef LRF_TLAST_RESYNC_EN
        exp_cyc("tl_next", 1, 1, 0, 0, 1, 0, 0, 0);
`else
        exp_cyc("tl_next", 1, 1, 1, 2, 0, 0, 0, 0);
`endif
        check("tl_next.err", int'(err), 1);
        nxt();
        exp_cyc("tl_next2", 1, 1, `ifdef LRF_TLAST_RESYNC_EN 0, 1, 1 `else 1, 3, 0 `endif, 0, 0, 0);
        check("tl_hold.err", int'(err), 1);

        // reset at frame 1 beat 2
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0; en = 1'b1; tl = 1'b0;
        exp_cyc("rst2_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            nxt(); tl = (k % 4 == 3);
            exp_cyc($sformatf("grpD%0d", k), 1, 1, int'(k < 4), k % 4, k / 4, 0, 0, 0);
        end
        nxt(); rst = 1'b1; tl = 1'b0;
        exp_cyc("pre_rst", 1, 1, 0, 2, 1, 0, 0, 0);
        nxt(); rst = 1'b0; en = 1'b0;
        exp_cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst.err", int'(err), 0);
        for (int c = 0; c < 3; c++) begin
            nxt();
            check($sformatf("post_rst_done%0d", c), int'(done), 0);
        end

        // FUSE_COUNT=1
        nxt(); rst1 = 1'b0; en1 = 1'b1; tv1 = 1'b1; mr1 = 1'b1;
        exp_cyc1("f1_idle", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            nxt(); tl1 = (k % 4 == 3);
            exp_cyc1($sformatf("f1_%0d", k), 1, 1, 1, k % 4, 1, int'(k % 4 == 3), int'(k == 4));
        end
        nxt(); tv1 = 1'b0; tl1 = 1'b0;
        exp_cyc1("f1_novalid", 1, 0, 1, 0, 0, 0, 1);
        nxt(); tv1 = 1'b1;
        exp_cyc1("f1_resume", 1, 1, 1, 0, 1, 0, 0);
        check("f1.err", int'(err1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
